serial_ram_loader: RTL and testbench

Framed program loader between the UART receiver and the 8-bit computer's 16×8 RAM. Consumes the receiver's one-cycle byte-valid strobe and byte. Parses 4-byte frames (sync, address, data, checksum) and issues one-cycle RAM write pulses for good frames. Raises a CPU-halt request while a load session is open and returns an ACK/NAK byte for the UART transmitter.

---
 rtl/serial_ram_loader.sv | 193 +++++++++++++++++++
 tb/tb_serial_ram_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ram_loader.sv
// serial_ram_loader
// Framed program loader sitting between the UART receiver and the 16x8 RAM
// of the 8-bit computer. It accepts 4-byte frames (sync, address, data,
// checksum) and writes RAM for good write frames. It holds the CPU halted
// while a load session is open and answers every complete frame with an
// ACK (8'h06) or NAK (8'h15) byte for the UART transmitter.
//
// Ports
//   clk          system clock (single domain)
//   reset        asynchronous, active-high reset
//   rx_dv        one-cycle strobe, rx_byte valid
//   rx_byte      received byte
//   ram_we       one-cycle RAM write strobe
//   ram_addr     RAM write address, held until the next write
//   ram_data     RAM write data, held until the next write
//   load_active  session open; the CPU must stay halted while high
//   ack_dv       one-cycle strobe to the UART transmitter
//   ack_byte     ACK/NAK byte, held until the next ack_dv
//   err_count    saturating count of rejected or timed-out frames
module serial_ram_loader #(
  parameter int          TIMEOUT_CLKS = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       load_active,
  output logic       ack_dv,
  output logic [7:0] ack_byte,
  output logic [7:0] err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  localparam logic [7:0] ACK_CODE = 8'h06;
  localparam logic [7:0] NAK_CODE = 8'h15;
  localparam logic [7:0] END_ADDR = 8'h80;

  localparam int         TW       = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  // Running XOR checksum: fold one more byte into the accumulator.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    chk_update = acc ^ b;
  endfunction

  // Error counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

  logic [1:0]    state_r,    state_s;
  logic [TW-1:0] timer_r,    timer_s;
  logic [7:0]    chk_acc_r,  chk_acc_s;
  logic [7:0]    a_reg_r,    a_reg_s;
  logic [7:0]    d_reg_r,    d_reg_s;
  logic          ram_we_r,   ram_we_s;
  logic [3:0]    ram_addr_r, ram_addr_s;
  logic [7:0]    ram_data_r, ram_data_s;
  logic          load_r,     load_s;
  logic          ack_dv_r,   ack_dv_s;
  logic [7:0]    ack_byte_r, ack_byte_s;
  logic [7:0]    err_r,      err_s;
  logic          timeout_s;
  logic          chk_ok_s;

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    chk_acc_s  = chk_acc_r;
    a_reg_s    = a_reg_r;
    d_reg_s    = d_reg_r;
    ram_we_s   = 1'b0;
    ram_addr_s = ram_addr_r;
    ram_data_s = ram_data_r;
    load_s     = load_r;
    ack_dv_s   = 1'b0;
    ack_byte_s = ack_byte_r;
    err_s      = err_r;

    // A byte arriving in the timeout cycle wins over the timeout.
    timeout_s = (state_r != ST_IDLE) && !rx_dv && (timer_r == TIMER_LAST);
    chk_ok_s  = (rx_byte == chk_acc_r);

    if (rx_dv || (state_r == ST_IDLE)) begin
      timer_s = {TW{1'b0}};
    end else begin
      timer_s = timer_r + TW'(1);
    end

    if (rx_dv) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            state_s   = ST_ADDR;
            chk_acc_s = SYNC_BYTE;
            load_s    = 1'b1;
          end else begin
            state_s   = ST_IDLE;
          end
        end
        ST_ADDR: begin
          a_reg_s   = rx_byte;
          chk_acc_s = chk_update(chk_acc_r, rx_byte);
          state_s   = ST_DATA;
        end
        ST_DATA: begin
          d_reg_s   = rx_byte;
          chk_acc_s = chk_update(chk_acc_r, rx_byte);
          state_s   = ST_CHK;
        end
        ST_CHK: begin
          state_s  = ST_IDLE;
          ack_dv_s = 1'b1;
          if (chk_ok_s && (a_reg_r[7:4] == 4'd0)) begin
            ram_we_s   = 1'b1;
            ram_addr_s = a_reg_r[3:0];
            ram_data_s = d_reg_r;
            ack_byte_s = ACK_CODE;
          end else if (chk_ok_s && (a_reg_r == END_ADDR)) begin
            load_s     = 1'b0;
            ack_byte_s = ACK_CODE;
          end else begin
            ack_byte_s = NAK_CODE;
            err_s      = sat_inc(err_r);
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      // Abandon the partial frame silently; the host sees no ack.
      state_s = ST_IDLE;
      timer_s = {TW{1'b0}};
      err_s   = sat_inc(err_r);
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      timer_r    <= {TW{1'b0}};
      chk_acc_r  <= 8'h00;
      a_reg_r    <= 8'h00;
      d_reg_r    <= 8'h00;
      ram_we_r   <= 1'b0;
      ram_addr_r <= 4'h0;
      ram_data_r <= 8'h00;
      load_r     <= 1'b0;
      ack_dv_r   <= 1'b0;
      ack_byte_r <= 8'h00;
      err_r      <= 8'h00;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      chk_acc_r  <= chk_acc_s;
      a_reg_r    <= a_reg_s;
      d_reg_r    <= d_reg_s;
      ram_we_r   <= ram_we_s;
      ram_addr_r <= ram_addr_s;
      ram_data_r <= ram_data_s;
      load_r     <= load_s;
      ack_dv_r   <= ack_dv_s;
      ack_byte_r <= ack_byte_s;
      err_r      <= err_s;
    end
  end

  assign ram_we      = ram_we_r;
  assign ram_addr    = ram_addr_r;
  assign ram_data    = ram_data_r;
  assign load_active = load_r;
  assign ack_dv      = ack_dv_r;
  assign ack_byte    = ack_byte_r;
  assign err_count   = err_r;

endmodule

// File: tb/tb_serial_ram_loader.sv
// Testbench for serial_ram_loader: directed frames from the test plan plus
// randomized frame traffic, compared every cycle against a frame-buffer
// reference model.
module tb_serial_ram_loader;

  localparam int         TO   = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       load_active;
  logic       ack_dv;
  logic [7:0] ack_byte;
  logic [7:0] err_count;

  serial_ram_loader #(.TIMEOUT_CLKS(TO), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .load_active(load_active), .ack_dv(ack_dv), .ack_byte(ack_byte),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes of the frame collected so far.
  logic [7:0] frame_q[$];
  int         idle_cnt;
  logic       exp_we, exp_load, exp_ack_dv;
  logic [3:0] exp_addr;
  logic [7:0] exp_data, exp_ack, exp_err;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    idle_cnt   = 0;
    exp_we     = 1'b0;
    exp_load   = 1'b0;
    exp_ack_dv = 1'b0;
    exp_addr   = 4'h0;
    exp_data   = 8'h00;
    exp_ack    = 8'h00;
    exp_err    = 8'h00;
  endtask

  task automatic bump_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  // One clock of the reference model: buffer a frame, judge it when complete.
  task automatic model_clk(input logic dv, input logic [7:0] b);
    logic [7:0] a, d;
    logic       sum_ok;
    exp_we     = 1'b0;
    exp_ack_dv = 1'b0;
    if (dv) begin
      idle_cnt = 0;
      if (frame_q.size() == 0) begin
        if (b == SYNC) begin
          frame_q.push_back(b);
          exp_load = 1'b1;
        end
      end else begin
        frame_q.push_back(b);
        if (frame_q.size() == 4) begin
          a = frame_q[1];
          d = frame_q[2];
          sum_ok = ((frame_q[0] ^ a ^ d) == frame_q[3]);
          exp_ack_dv = 1'b1;
          if (sum_ok && a < 8'd16) begin
            exp_we   = 1'b1;
            exp_addr = a[3:0];
            exp_data = d;
            exp_ack  = 8'h06;
          end else if (sum_ok && a == 8'h80) begin
            exp_load = 1'b0;
            exp_ack  = 8'h06;
          end else begin
            exp_ack = 8'h15;
            bump_err();
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TO) begin
        frame_q.delete();
        idle_cnt = 0;
        bump_err();
      end
    end
  endtask

  task automatic check_all();
    check("ram_we",      8'(ram_we),      8'(exp_we));
    check("ram_addr",    8'(ram_addr),    8'(exp_addr));
    check("ram_data",    ram_data,        exp_data);
    check("load_active", 8'(load_active), 8'(exp_load));
    check("ack_dv",      8'(ack_dv),      8'(exp_ack_dv));
    check("ack_byte",    ack_byte,        exp_ack);
    check("err_count",   err_count,       exp_err);
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic step(input logic dv, input logic [7:0] b);
    rx_dv   = dv;
    rx_byte = b;
    @(posedge clk);
    model_clk(dv, b);
    @(negedge clk);
    rx_dv = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    step(1'b1, SYNC);
    step(1'b1, a);
    step(1'b1, d);
    step(1'b1, c);
  endtask

  initial begin
    logic [7:0] ra, rd, rc;
    int         kind;
    model_reset();
    reset   = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    idle(2);

    // Good write frame.
    frame(8'h03, 8'h3C, 8'h9A);
    check("tp_write_we",   8'(ram_we), 8'd1);
    check("tp_write_addr", 8'(ram_addr), 8'd3);
    check("tp_write_data", ram_data, 8'h3C);
    check("tp_write_ack",  ack_byte, 8'h06);
    check("tp_write_load", 8'(load_active), 8'd1);
    idle(1);

    // Bad checksum, then a good retry.
    frame(8'h03, 8'h3C, 8'h00);
    check("tp_badsum_ack", ack_byte, 8'h15);
    check("tp_badsum_err", err_count, 8'd1);
    frame(8'h03, 8'h3C, 8'h9A);
    check("tp_retry_we", 8'(ram_we), 8'd1);

    // Malformed address, then END frame.
    frame(8'h13, 8'h00, 8'hB6);
    check("tp_malformed_we",  8'(ram_we), 8'd0);
    check("tp_malformed_ack", ack_byte, 8'h15);
    frame(8'h80, 8'h00, 8'h25);
    check("tp_end_ack",  ack_byte, 8'h06);
    check("tp_end_load", 8'(load_active), 8'd0);

    // Timeout mid-frame; the late byte is ignored as non-sync.
    step(1'b1, SYNC);
    step(1'b1, 8'h03);
    idle(TO);
    check("tp_timeout_err", err_count, 8'd3);
    step(1'b1, 8'h3C);
    idle(3);
    check("tp_late_byte_err", err_count, 8'd3);

    // Sixteen zero-gap writes in order.
    for (int i = 0; i < 16; i++) begin
      ra = 8'(i);
      rd = ra ^ 8'hFF;
      frame(ra, rd, SYNC ^ ra ^ rd);
      check("tp_b2b_addr", 8'(ram_addr), ra);
      check("tp_b2b_data", ram_data, rd);
    end

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) frame(8'h03, 8'h3C, 8'h00);
    check("tp_err_sat", err_count, 8'hFF);

    // Reset in the middle of a frame.
    step(1'b1, SYNC);
    step(1'b1, 8'h03);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    frame(8'h07, 8'h55, SYNC ^ 8'h07 ^ 8'h55);
    check("tp_post_reset_we",   8'(ram_we), 8'd1);
    check("tp_post_reset_addr", 8'(ram_addr), 8'd7);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      ra = 8'($urandom_range(0, 15));
      rd = 8'($urandom);
      rc = SYNC ^ ra ^ rd;
      case (kind)
        0, 1, 2, 3: ;
        4: rc = rc ^ 8'(1 << $urandom_range(0, 7));
        5: begin ra = 8'h80; rc = SYNC ^ ra ^ rd; end
        6: begin ra = 8'($urandom); rc = SYNC ^ ra ^ rd; end
        default: ;
      endcase
      if (kind == 7) begin
        step(1'b1, 8'($urandom));
      end else if (kind == 8) begin
        step(1'b1, SYNC);
        step(1'b1, ra);
        idle($urandom_range(TO - 3, TO + 3));
      end else begin
        step(1'b1, SYNC);
        idle($urandom_range(0, 2));
        step(1'b1, ra);
        idle($urandom_range(0, 2));
        step(1'b1, rd);
        idle($urandom_range(0, 2));
        step(1'b1, rc);
      end
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
